// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front-end blocks.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    localparam int SA_DATA_WIDTH = 8;
    localparam int SA_ROWS       = 4;

    // Width of a counter that must hold values up to rows-1 (at least 1 bit).
    function automatic int flush_count_width(input int rows);
        return (rows < 2) ? 1 : $clog2(rows);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register pipeline carrying one activation lane plus its valid bit.
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] lane_data,
    input  logic                  lane_valid,
    output logic [DATA_WIDTH-1:0] tap_data,
    output logic                  tap_valid
);

    logic [DATA_WIDTH-1:0] data_reg  [DEPTH];
    logic                  valid_reg [DEPTH];
    logic [DATA_WIDTH-1:0] stage_data  [DEPTH];
    logic                  stage_valid [DEPTH];

    // Each stage is fed by the lane input (stage 0) or by the previous stage.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_data[gi]  = lane_data;
                assign stage_valid[gi] = lane_valid;
            end else begin : g_tail
                assign stage_data[gi]  = data_reg[gi-1];
                assign stage_valid[gi] = valid_reg[gi-1];
            end
        end
    endgenerate

    // Advance every stage each cycle; clear the whole line on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i]  <= '0;
                valid_reg[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i]  <= stage_data[i];
                valid_reg[i] <= stage_valid[i];
            end
        end
    end

    assign tap_data  = data_reg[DEPTH-1];
    assign tap_valid = valid_reg[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Left-edge feeder: accepts activation vectors, skews them diagonally across
// rows, flushes after the last vector and pulses done for the array controller.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int ROWS       = SA_ROWS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic [ROWS-1:0]            out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int             CW         = flush_count_width(ROWS);
    localparam logic [CW-1:0]  FLUSH_LOAD = CW'(ROWS - 1);
    localparam logic [CW-1:0]  COUNT_ONE  = CW'(1);

    feeder_state_t             state_reg, state_next;
    logic [CW-1:0]             count_reg, count_next;
    logic                      busy_reg, busy_next;
    logic                      done_reg, done_next;
    logic                      accept;
    logic [ROWS*DATA_WIDTH-1:0] lane_data;

    // Ready depends on state only, so there is no path from in_valid.
    assign in_ready  = (state_reg == IDLE) || (state_reg == STREAM);
    assign accept    = in_valid && in_ready;
    // Non-accepted cycles inject zero-valued bubbles into every row.
    assign lane_data = accept ? in_data : '0;

    // Next-state, flush counter and registered status flags.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        if (ROWS == 1) begin
                            state_next = DONE;
                        end else begin
                            state_next = FLUSH;
                            count_next = FLUSH_LOAD;
                        end
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            FLUSH: begin
                // Leaving on the edge where the count reaches zero lines done
                // up with the last row's final valid sample.
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next == STREAM) || (state_next == FLUSH);
        done_next = (state_next == DONE);
    end

    // State, counter and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

    // Row r gets a delay line of depth r+1.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            skew_delay_line #(
                .DEPTH      (gi + 1),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_line (
                .clk        (clk),
                .rst_n      (rst_n),
                .lane_data  (lane_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .lane_valid (accept),
                .tap_data   (out_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .tap_valid  (out_valid[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (ROWS=4 main instance, ROWS=1 side instance).
module tb_systolic_skew_feeder;

    localparam int DW   = 8;
    localparam int ROWS = 4;
    localparam int W    = DW * ROWS;
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, in_valid, in_ready, in_last, busy, done;
    logic [W-1:0]   in_data, out_data;
    logic [ROWS-1:0] out_valid;

    logic           rst1_n, v1, r1, l1, busy1, done1, ov1;
    logic [DW-1:0]  d1, od1;

    int tests = 0;
    int fails = 0;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_data(out_data),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    systolic_skew_feeder #(.DATA_WIDTH(DW), .ROWS(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(v1), .in_ready(r1),
        .in_data(d1), .in_last(l1), .out_data(od1),
        .out_valid(ov1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Records every accepted vector by cycle number; expected outputs are
    // looked up as "what was accepted r+1 cycles ago", and the handshake
    // status follows from the cycle of the last accepted in_last.
    logic         hist_v [HMAX];
    logic [W-1:0] hist_d [HMAX];
    int  cyc     = 0;
    int  floor_c = 0;
    int  last_c  = -1000;
    bit  stream  = 0;
    logic            m_rdy, m_done, m_busy;
    logic [ROWS-1:0] m_v;
    logic [W-1:0]    m_d;

    initial begin
        for (int i = 0; i < HMAX; i++) begin
            hist_v[i] = 1'b0;
            hist_d[i] = '0;
        end
        forever begin
            @(posedge clk);
            if (cyc >= HMAX) begin
                $display("FAIL model_budget: got cycle %0d expected below %0d", cyc, HMAX);
                $fatal(1, "cycle budget exceeded");
            end
            if (!rst_n) begin
                floor_c     = cyc + 1;
                last_c      = -1000;
                stream      = 0;
                hist_v[cyc] = 1'b0;
            end else begin
                bit rdy;
                rdy = !(cyc > last_c && cyc <= last_c + ROWS);
                hist_v[cyc] = in_valid && rdy;
                hist_d[cyc] = in_data;
                if (in_valid && rdy) begin
                    if (in_last) begin
                        last_c = cyc;
                        stream = 0;
                    end else begin
                        stream = 1;
                    end
                end
            end
            cyc++;
            #1;
            m_rdy  = !(cyc > last_c && cyc <= last_c + ROWS);
            m_done = (cyc == last_c + ROWS);
            m_busy = stream || (cyc > last_c && cyc < last_c + ROWS);
            m_v    = '0;
            m_d    = '0;
            for (int r = 0; r < ROWS; r++) begin
                int idx;
                idx = cyc - r - 1;
                if (idx >= floor_c && idx >= 0 && hist_v[idx]) begin
                    m_v[r]         = 1'b1;
                    m_d[r*DW +: DW] = hist_d[idx][r*DW +: DW];
                end
            end
            chk("model_ready", 32'(in_ready), 32'(m_rdy));
            chk("model_done",  32'(done),     32'(m_done));
            chk("model_busy",  32'(busy),     32'(m_busy));
            chk("model_valid", 32'(out_valid), 32'(m_v));
            chk("model_data",  out_data,       m_d);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic            v;
        logic            last;
        logic [W-1:0]    d;
        logic            rdy;
        logic [ROWS-1:0] ev;
        logic [W-1:0]    ed;
        logic            edone;
        logic            ebusy;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // single vector 1,2,3,4 with last
        tbl[0]  = '{1'b1, 1'b1, 32'h04030201, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0001, 32'h00000001, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0010, 32'h00000200, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0100, 32'h00030000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1000, 32'h04000000, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0};
        // -128, 127, -1 back to back, last on the third
        tbl[6]  = '{1'b1, 1'b0, 32'h80808080, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h7f7f7f7f, 1'b1, 4'b0001, 32'h00000080, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 32'hffffffff, 1'b1, 4'b0011, 32'h0000807f, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0111, 32'h00807fff, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1110, 32'h807fff00, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1100, 32'h7fff0000, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1000, 32'hff000000, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0};
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        rst1_n = 1'b0; v1 = 1'b0; l1 = 1'b0; d1 = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_data",  out_data, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst1_ready", 32'(r1), 32'h1);
        chk("rst1_out",  {22'h0, done1, ov1, od1}, 32'h0);
        rst_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);

        // table-driven sequences
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data",  i), out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_done",  i), 32'(done), 32'(tbl[i].edone));
            chk($sformatf("tbl%0d_busy",  i), 32'(busy), 32'(tbl[i].ebusy));
            in_valid = tbl[i].v;
            in_last  = tbl[i].last;
            in_data  = tbl[i].d;
        end

        // bubble: 5, bubble, 6+last
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int r = 0; r < ROWS; r++) begin
                int off;
                logic [8:0] exp;
                off = k - r - 1;
                exp = (off == 0) ? 9'h105 : (off == 2) ? 9'h106 : 9'h000;
                chk($sformatf("bubble_k%0d_r%0d", k, r), {23'h0, out_valid[r], out_data[r*DW +: DW]}, 32'(exp));
            end
            chk($sformatf("bubble_done_k%0d", k), 32'(done), 32'(k == 6));
            in_valid = (k == 0) || (k == 2);
            in_last  = (k == 2);
            in_data  = (k == 0) ? 32'h05050505 : 32'h06060606;
        end
        in_valid = 1'b0; in_last = 1'b0;

        // in_valid held through FLUSH: consumed only once IDLE returns
        for (int k = 0; k <= 10; k++) begin
            logic [8:0] exp0;
            @(negedge clk);
            exp0 = (k == 1) ? 9'h109 : (k == 6) ? 9'h10a : 9'h000;
            chk($sformatf("hold_ready_k%0d", k), 32'(in_ready),
                32'(!((k >= 1 && k <= 4) || (k >= 6 && k <= 9))));
            chk($sformatf("hold_row0_k%0d", k), {23'h0, out_valid[0], out_data[DW-1:0]}, 32'(exp0));
            in_valid = (k <= 5);
            in_last  = 1'b1;
            in_data  = (k == 0) ? 32'h09090909 : 32'h0a0a0a0a;
        end
        in_valid = 1'b0; in_last = 1'b0;

        // reset for one cycle in mid-STREAM
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) chk("midrst_busy_before", 32'(busy), 32'h1);
            if (k == 4) begin
                chk("midrst_data",  out_data, 32'h0);
                chk("midrst_valid", 32'(out_valid), 32'h0);
                chk("midrst_ready", 32'(in_ready), 32'h1);
                chk("midrst_busy",  32'(busy), 32'h0);
            end
            if (k >= 4) chk($sformatf("midrst_nodone_k%0d", k), 32'(done), 32'h0);
            rst_n    = (k != 3);
            in_valid = (k < 3);
            in_last  = 1'b0;
            in_data  = 32'h11223344;
        end
        in_valid = 1'b0;

        // ROWS=1 instance: output and done on the same cycle
        @(negedge clk);
        v1 = 1'b1; l1 = 1'b1; d1 = 8'h07;
        @(negedge clk);
        v1 = 1'b0; l1 = 1'b0;
        chk("r1_data",  32'(od1), 32'h07);
        chk("r1_valid", 32'(ov1), 32'h1);
        chk("r1_done",  32'(done1), 32'h1);
        chk("r1_busy",  32'(busy1), 32'h0);
        chk("r1_ready_done", 32'(r1), 32'h0);
        @(negedge clk);
        chk("r1_ready_idle", 32'(r1), 32'h1);
        chk("r1_after", {22'h0, done1, ov1, od1}, 32'h0);

        // randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 299) != 0);
            in_valid = ($urandom_range(0, 99) < 70);
            in_last  = ($urandom_range(0, 9) == 0);
            in_data  = $urandom;
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
